// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: segment patterns and FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_scan_driver_pkg;

  // Active-high segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Scan FSM: dark until the first tick, then alternating one-cycle guard and digit slot
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// BCD nibble to active-high 7-segment pattern; non-decimal codes show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Table lookup; 10..15 are not valid BCD so they render as a dash
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame digit snapshot and guard slot.
// Latency: tick in cycle T -> anodes off at T+1, new digit visible from T+2 until next tick.
// Backpressure: none; i_en low freezes the prescaler and holds the display steady.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_bcd,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_tick
);

  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PS_MAX  = PW'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);

  // Inactive levels; XOR with these converts an active-high value to the pin polarity
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]        r_presc;
  logic [IDX_W-1:0]     r_idx;
  logic [4*DIGITS-1:0]  r_shadow;
  logic [DIGITS-1:0]    r_shadow_dp;
  state_t               r_state;

  logic                 w_tick;
  logic [3:0]           w_nib;
  logic                 w_dp_sel;
  logic                 w_blank;
  logic [DIGITS-1:0]    w_an_hot;
  logic [6:0]           w_seg_hi;

  assign w_tick = i_en && (r_presc == PS_MAX);

  // Slot prescaler: counts enabled cycles and wraps on the slot tick
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else if (i_en) begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Select the current shadow digit, its dp bit and anode, and decide leading-zero blanking
  always_comb begin
    logic v_upper_zero;
    w_nib        = 4'd0;
    w_dp_sel     = 1'b0;
    w_blank      = 1'b0;
    w_an_hot     = '0;
    v_upper_zero = 1'b1;
    // Walk from the most significant digit down so v_upper_zero covers digits DIGITS-1..k
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (r_shadow[4*k +: 4] != 4'd0) begin
        v_upper_zero = 1'b0;
      end
      if (k == int'(r_idx)) begin
        w_nib       = r_shadow[4*k +: 4];
        w_dp_sel    = r_shadow_dp[k];
        w_blank     = i_blank_lz && (k != 0) && v_upper_zero;
        w_an_hot[k] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_nib),
    .o_seg (w_seg_hi)
  );

  // Scan FSM with registered display outputs; the guard cycle kills the anodes between digits
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      o_seg       <= SEG_OFF;
      o_dp        <= DP_OFF;
      o_an        <= AN_OFF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_seg <= SEG_OFF;
          o_dp  <= DP_OFF;
          o_an  <= AN_OFF;
          if (w_tick) begin
            r_shadow    <= i_bcd;
            r_shadow_dp <= i_dp;
            r_idx       <= '0;
            r_state     <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          // Single cycle, independent of i_en, so a frozen scan never sits in the dark
          if (w_blank) begin
            o_seg <= SEG_OFF;
            o_dp  <= DP_OFF;
            o_an  <= AN_OFF;
          end else begin
            o_seg <= w_seg_hi ^ SEG_OFF;
            o_dp  <= w_dp_sel ^ DP_OFF;
            o_an  <= w_an_hot ^ AN_OFF;
          end
          r_state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (w_tick) begin
            // Shadow only reloads on the frame wrap so a rolling counter cannot tear
            if (r_idx == IDX_MAX) begin
              r_idx       <= '0;
              r_shadow    <= i_bcd;
              r_shadow_dp <= i_dp;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
            o_an    <= AN_OFF;
            r_state <= ST_GUARD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered tick strobe, one cycle after the slot tick
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tick <= 1'b0;
    end else begin
      o_tick <= w_tick;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, PRESCALE=4, active-low pins).
// Reference model works from tick counts and frame snapshots rather than a state machine.
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_en;
  logic [15:0] i_bcd;
  logic [3:0]  i_dp;
  logic        i_blank_lz;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS         (DIGITS),
    .PRESCALE       (PRESCALE),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_bcd      (i_bcd),
    .i_dp       (i_dp),
    .i_blank_lz (i_blank_lz),
    .o_seg      (o_seg),
    .o_dp       (o_dp),
    .o_an       (o_an),
    .o_tick     (o_tick)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          en_cycles;
  int          ticks;
  bit          guard_now;
  logic [15:0] snap;
  logic [3:0]  snapdp;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'd0: pat = 7'h3F;
      4'd1: pat = 7'h06;
      4'd2: pat = 7'h5B;
      4'd3: pat = 7'h4F;
      4'd4: pat = 7'h66;
      4'd5: pat = 7'h6D;
      4'd6: pat = 7'h7D;
      4'd7: pat = 7'h07;
      4'd8: pat = 7'h7F;
      4'd9: pat = 7'h6F;
      default: pat = 7'h40;
    endcase
  endfunction

  task automatic reset_model();
    en_cycles = 0;
    ticks     = 0;
    guard_now = 1'b0;
    snap      = '0;
    snapdp    = '0;
    e_seg     = 7'h7F;
    e_dp      = 1'b1;
    e_an      = 4'hF;
    e_tick    = 1'b0;
  endtask

  // Predict the effect of the current cycle's inputs, clock once, compare all outputs
  task automatic cycle();
    bit          tk;
    bit          blank;
    int          d;
    logic [15:0] upper;
    logic [3:0]  one;
    one = 4'b0001;
    tk  = i_en && ((en_cycles % PRESCALE) == PRESCALE - 1);
    if (i_en) en_cycles++;
    e_tick = tk;
    if (tk) begin
      ticks++;
      if (((ticks - 1) % DIGITS) == 0) begin
        snap   = i_bcd;
        snapdp = i_dp;
      end
      e_an      = 4'hF;
      guard_now = 1'b1;
    end else if (guard_now) begin
      d     = (ticks - 1) % DIGITS;
      upper = snap >> (4 * d);
      blank = i_blank_lz && (d > 0) && (upper == 16'h0);
      if (blank) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end else begin
        e_an  = ~(one << d);
        e_seg = ~pat(snap[4*d +: 4]);
        e_dp  = ~snapdp[d];
      end
      guard_now = 1'b0;
    end
    @(posedge clk);
    #1;
    check("an",   o_an,   e_an);
    check("seg",  o_seg,  e_seg);
    check("dp",   o_dp,   e_dp);
    check("tick", o_tick, e_tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 2) != 0) v[4*k +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  initial begin
    i_rst_n    = 1'b1;
    i_en       = 1'b1;
    i_bcd      = 16'h1234;
    i_dp       = 4'b0000;
    i_blank_lz = 1'b0;
    #2;
    i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_an",   o_an,   4'hF);
    check("rst_seg",  o_seg,  7'h7F);
    check("rst_dp",   o_dp,   1'b1);
    check("rst_tick", o_tick, 1'b0);

    // Release: cycle 0 begins now; tick expected in cycle 3
    i_rst_n = 1'b1;
    reset_model();
    run(4);
    check("c4_an",  o_an,  4'hF);
    check("c4_seg", o_seg, 7'h7F);
    run(1);
    check("c5_an",  o_an,  4'b1110);
    check("c5_seg", o_seg, 7'h19);

    // Scan order through two full frames
    run(32);

    // Leading zeros
    i_blank_lz = 1'b1;
    i_bcd      = 16'h0050;
    run(32);
    i_bcd = 16'h0000;
    run(32);

    // Frame coherency: change digits mid-frame
    i_blank_lz = 1'b0;
    i_bcd      = 16'h1234;
    run(22);
    i_bcd = 16'h5678;
    run(32);

    // Enable hold during a digit slot
    run(2);
    i_en = 1'b0;
    run(20);
    i_en = 1'b1;
    run(16);

    // Invalid nibble with dp, then blanked digits requesting dp
    i_bcd = 16'h000A;
    i_dp  = 4'b0001;
    run(32);
    i_bcd      = 16'h0005;
    i_dp       = 4'b1111;
    i_blank_lz = 1'b1;
    run(32);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      i_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) i_bcd = rand_bcd();
      if ($urandom_range(0, 9) == 0) i_dp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) i_blank_lz = 1'($urandom_range(0, 1));
      cycle();
    end

    // Asynchronous reset mid-slot, no clock edge needed
    i_en  = 1'b1;
    i_bcd = 16'h1234;
    run(9);
    i_rst_n = 1'b0;
    #1;
    check("arst_an",   o_an,   4'hF);
    check("arst_seg",  o_seg,  7'h7F);
    check("arst_dp",   o_dp,   1'b1);
    check("arst_tick", o_tick, 1'b0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 60; i++) begin
      i_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) i_bcd = rand_bcd();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
